vga_pixel_out: RTL and testbench
================================

# vga_pixel_out

Raster timing and pixel output stage downstream of the 8-to-4-bit colour dithering stage. Generates horizontal/vertical counters and sync pulses for a 4-bit-per-channel VGA DAC. Publishes the current pixel coordinate so upstream stages can fetch and dither the pixel. Registers the returned 12-bit colour with blanking so RGB and sync leave the block time-aligned.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel tick, one clk wide (e.g. 1 in 4 at 100 MHz for 25 MHz pixels)
- test_mode  in  1  selects internal colour bars; used only with VGA_TEST_PATTERN_EN
- R_in, G_in, B_in  in  4 each  dithered colour for the coordinate currently on hcount/vcount
- hcount  out  10  current horizontal position, 0..H_TOTAL-1
- vcount  out  10  current vertical position, 0..V_TOTAL-1
- active  out  1  hcount<H_ACTIVE and vcount<V_ACTIVE (combinational from counters)
- frame_start  out  1  one-clk pulse on the pix_en that moves counters to (0,0)
- vga_r, vga_g, vga_b  out  4 each  registered colour to DAC
- hsync, vsync  out  1 each  registered, active-low sync

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; counters are 10 bits.
- Counters change only on clk edges where pix_en=1. Otherwise all registers hold.
- hcount increments and wraps H_TOTAL-1 → 0. On that wrap, vcount increments and wraps V_TOTAL-1 → 0. The simultaneous wrap of both raises frame_start for that clk.
- Sync (pre-register): hsync low while H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. vsync low while V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC.
- Colour (pre-register): R/G/B_in when active=1, else 0x0. Blanking must force zero regardless of inputs.
- On a pix_en edge, vga_r/g/b, hsync and vsync register the pre-register values for the current coordinate. The counters advance on the same edge.
- R_in/G_in/B_in are sampled only at pix_en edges. Upstream has a full pixel period (minus the clk edge) to respond to a new hcount/vcount.
- reset_n low (asynchronous, any time, including mid-line) forces: hcount=0, vcount=0, vga_r/g/b=0, hsync=1, vsync=1, frame_start=0. active then reads 1 because (0,0) is visible.
- After reset release, the first pix_en registers pixel (0,0) and moves hcount to 1. frame_start is not pulsed for the post-reset frame.

## Timing
- Latency: coordinate → DAC output = 1 pix_en tick. Sync is delayed identically, so RGB, hsync and vsync stay pixel-aligned.
- frame_start is a registered pulse one clk wide, asserted the clk after the wrap edge.
- Line period: H_TOTAL ticks. Frame period: H_TOTAL·V_TOTAL ticks (420000 by default).
- pix_en held high continuously is legal; the block then runs at the clk rate.

## Configuration
- VGA_TEST_PATTERN_EN defined: when test_mode=1, the active-region colour is taken from internal bars instead of R/G/B_in.
- Bar index is hcount[9:7]. The colour sequence for index 0..7 is: white F/F/F, yellow F/F/0, cyan 0/F/F, green 0/F/0, magenta F/0/F, red F/0/0, blue 0/0/F, black 0/0/0.
- Blanking still forces 0 in test mode.
- VGA_TEST_PATTERN_EN not defined: test_mode is ignored and no bar logic is synthesised.

## Test plan
- Reset: assert reset_n=0 mid-line (hcount=300, vcount=100) → hcount=0, vcount=0, rgb=0, hsync=vsync=1 immediately, without waiting for a clk edge.
- Line timing: pix_en every 4th clk, R/G/B_in=A/5/3 → hsync low for exactly 96 ticks. After the 1-tick delay, the fall is seen when hcount=657. rgb=A/5/3 for 640 ticks and 0 for 160 ticks.
- Frame timing: run 2 frames → vsync low for 2 lines (1600 ticks) starting after line 489. frame_start pulses every 420000 ticks.
- Blanking: hold inputs F/F/F → vga outputs are 0 whenever the previous coordinate had hcount≥640 or vcount≥480.
- pix_en gating: hold pix_en=0 for 50 clks mid-line → counters and all outputs hold their values.
- Test pattern (macro defined, test_mode=1): at hcount=130 → registered colour F/F/0. At hcount=260 → 0/F/F. At hcount=700 → 0/0/0 (blanking).

Source files
------------

// File: rtl/vga_pixel_out.sv
// VGA raster timing and registered 4-bit-per-channel pixel output stage.
// Define VGA_TEST_PATTERN_EN to add internal colour bars selected by test_mode.
module vga_pixel_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic       test_mode,
  input  logic [3:0] R_in,
  input  logic [3:0] G_in,
  input  logic [3:0] B_in,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       active,
  output logic       frame_start,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_start_q, frame_start_d;

  logic        h_last, v_last, active_w;
  logic [11:0] src_rgb;

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] bar_rgb;

  always_comb begin
    bar_rgb = 12'h000;
    case (hcount_q[9:7])
      3'd0: bar_rgb = 12'hFFF;
      3'd1: bar_rgb = 12'hFF0;
      3'd2: bar_rgb = 12'h0FF;
      3'd3: bar_rgb = 12'h0F0;
      3'd4: bar_rgb = 12'hF0F;
      3'd5: bar_rgb = 12'hF00;
      3'd6: bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  assign src_rgb = test_mode ? bar_rgb : {R_in, G_in, B_in};
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign src_rgb = {R_in, G_in, B_in};
`endif

  always_comb begin
    h_last        = (hcount_q == H_LAST);
    v_last        = (vcount_q == V_LAST);
    active_w      = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      // Output registers capture the coordinate being left, so sync and colour share one tick of delay.
      rgb_d   = active_w ? src_rgb : 12'h000;
      hsync_d = !((hcount_q >= HS_START) && (hcount_q < HS_END));
      vsync_d = !((vcount_q >= VS_START) && (vcount_q < VS_END));
      if (h_last) begin
        hcount_d = 10'd0;
        if (v_last) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign active      = active_w;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out: a default-timing instance for line behaviour
// and a shrunken-timing instance so whole frames fit in a short run.
module tb_vga_pixel_out;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       test_mode = 1'b0;
  logic [3:0] R_in = 4'h0, G_in = 4'h0, B_in = 4'h0;
  logic [9:0] hcount, vcount;
  logic       active, frame_start, hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b;

  logic       s_pix_en = 1'b0;
  logic [9:0] s_hcount, s_vcount;
  logic       s_active, s_frame_start, s_hsync, s_vsync;
  logic [3:0] s_r, s_g, s_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_pixel_out dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .test_mode(test_mode),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync)
  );

  // 16 x 9 raster: active 8x4, hsync at h 10..12, vsync at v 5..6.
  vga_pixel_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .pix_en(s_pix_en), .test_mode(1'b0),
    .R_in(4'hF), .G_in(4'hF), .B_in(4'hF),
    .hcount(s_hcount), .vcount(s_vcount), .active(s_active), .frame_start(s_frame_start),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hsync), .vsync(s_vsync)
  );

  typedef struct {
    string       name;
    int          ticks;
    logic [11:0] rgb_in;
    int          exp_h;
    int          exp_v;
    logic [11:0] exp_rgb;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_act;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One pixel tick on the big instance: pix_en high for one clk in every four.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) pix_en = 1'b1;
      @(negedge clk) pix_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  function automatic int rgb_of();
    return int'({vga_r, vga_g, vga_b});
  endfunction

  initial begin
    int hs_low, fall_h, n_a53, n_zero;
    int mh, mv, fs_cnt, vs_low, first_fs, second_fs;
    logic [11:0] e_rgb;
    logic e_hs, e_vs, e_fs;

    vecs[0] = '{"first_px",   1, 12'hFFF,   1, 0, 12'hFFF, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{"last_act", 639, 12'h123, 640, 0, 12'h123, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"first_blk",  1, 12'hFFF, 641, 0, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"hs_fall",   16, 12'hFFF, 657, 0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"hs_last",   95, 12'hFFF, 752, 0, 12'h000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"hs_rise",    1, 12'hFFF, 753, 0, 12'h000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{"line_wrap", 47, 12'hFFF,   0, 1, 12'h000, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{"line1_px0",  1, 12'hA53,   1, 1, 12'hA53, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_h", int'(hcount), 0);
    chk("rst_hs", int'(hsync), 1);
    chk("rst_act", int'(active), 1);
    reset_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      {R_in, G_in, B_in} = vecs[k].rgb_in;
      tick(vecs[k].ticks);
      chk({vecs[k].name, "_h"},   int'(hcount), vecs[k].exp_h);
      chk({vecs[k].name, "_v"},   int'(vcount), vecs[k].exp_v);
      chk({vecs[k].name, "_rgb"}, rgb_of(), int'(vecs[k].exp_rgb));
      chk({vecs[k].name, "_hs"},  int'(hsync), int'(vecs[k].exp_hs));
      chk({vecs[k].name, "_vs"},  int'(vsync), int'(vecs[k].exp_vs));
      chk({vecs[k].name, "_act"}, int'(active), int'(vecs[k].exp_act));
      chk({vecs[k].name, "_fs"},  int'(frame_start), 0);
    end

    // Full line 2 with A/5/3 on the inputs.
    tick(799);
    chk("line2_start_h", int'(hcount), 0);
    chk("line2_start_v", int'(vcount), 2);
    {R_in, G_in, B_in} = 12'hA53;
    hs_low = 0; fall_h = -1; n_a53 = 0; n_zero = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (!hsync) begin
        if (hs_low == 0) fall_h = int'(hcount);
        hs_low++;
      end
      if (rgb_of() == 12'hA53) n_a53++;
      if (rgb_of() == 0) n_zero++;
    end
    chk("hs_low_ticks", hs_low, 96);
    chk("hs_fall_hcount", fall_h, 657);
    chk("rgb_active_ticks", n_a53, 640);
    chk("rgb_blank_ticks", n_zero, 160);

    // pix_en held low mid-line: nothing moves even though inputs change.
    tick(300);
    {R_in, G_in, B_in} = 12'h000;
    repeat (50) @(negedge clk);
    chk("hold_h", int'(hcount), 300);
    chk("hold_v", int'(vcount), 3);
    chk("hold_rgb", rgb_of(), 12'hA53);
    chk("hold_hs", int'(hsync), 1);
    chk("hold_vs", int'(vsync), 1);

    // Asynchronous reset mid-line, away from any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_h", int'(hcount), 0);
    chk("arst_v", int'(vcount), 0);
    chk("arst_rgb", rgb_of(), 0);
    chk("arst_hs", int'(hsync), 1);
    chk("arst_vs", int'(vsync), 1);
    chk("arst_fs", int'(frame_start), 0);
    chk("arst_act", int'(active), 1);
    @(negedge clk) reset_n = 1'b1;

    // Colour bars (or plain pass-through when the feature is compiled out).
    {R_in, G_in, B_in} = 12'h123;
    test_mode = 1'b1;
    tick(131);
`ifdef VGA_TEST_PATTERN_EN
    chk("bar_h130", rgb_of(), 12'hFF0);
`else
    chk("tm_ignored_h130", rgb_of(), 12'h123);
`endif
    tick(130);
`ifdef VGA_TEST_PATTERN_EN
    chk("bar_h260", rgb_of(), 12'h0FF);
`else
    chk("tm_ignored_h260", rgb_of(), 12'h123);
`endif
    tick(440);
    chk("bar_h700_blank", rgb_of(), 0);
    test_mode = 1'b0;

    // Small raster, pix_en continuously high, checked every clk against a reference raster.
    mh = 0; mv = 0; fs_cnt = 0; vs_low = 0; first_fs = -1; second_fs = -1;
    @(negedge clk) s_pix_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      e_rgb = (mh < 8 && mv < 4) ? 12'hFFF : 12'h000;
      e_hs  = !(mh >= 10 && mh < 13);
      e_vs  = !(mv >= 5 && mv < 7);
      e_fs  = (mh == 15 && mv == 8);
      mh = (mh == 15) ? 0 : mh + 1;
      if (mh == 0) mv = (mv == 8) ? 0 : mv + 1;
      @(negedge clk);
      chk("s_rgb", int'({s_r, s_g, s_b}), int'(e_rgb));
      chk("s_hs", int'(s_hsync), int'(e_hs));
      chk("s_vs", int'(s_vsync), int'(e_vs));
      chk("s_fs", int'(s_frame_start), int'(e_fs));
      chk("s_h", int'(s_hcount), mh);
      chk("s_v", int'(s_vcount), mv);
      chk("s_act", int'(s_active), int'(mh < 8 && mv < 4));
      if (!s_vsync) vs_low++;
      if (s_frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = i; else second_fs = i;
      end
    end
    s_pix_en = 1'b0;
    chk("s_vs_low_ticks", vs_low, 64);
    chk("s_fs_count", fs_cnt, 2);
    chk("s_fs_first", first_fs, 143);
    chk("s_fs_period", second_fs - first_fs, 144);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
